modulo_contador_sync_param: RTL and testbench

//   Parametrised synchronous up/down counter with T-flip-flop cells and a carry-lookahead enable chain.

---
 rtl/modulo_contador_sync_param_pkg.sv | 15 +
 rtl/modulo_contador_sync_param_celula.sv | 35 +++
 rtl/modulo_contador_sync_param.sv | 95 +++++++++
 tb/tb_modulo_contador_sync_param.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/modulo_contador_sync_param_pkg.sv
// Shared definitions for the modulo counter: direction encoding and the modulus sanity check.
package modulo_contador_sync_param_pkg;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

  // Legal range for the modulus: 2 .. 2**width, with width >= 2
  function automatic bit modulus_ok(input int width, input longint modulus);
    if (width < 2 || width > 31) return 1'b0;
    return (modulus >= 2) && (modulus <= (longint'(1) << width));
  endfunction

endpackage

// File: rtl/modulo_contador_sync_param_celula.sv
// One counter bit: a T flip-flop with a synchronous reload port and its slice of the lookahead AND chain.
module modulo_celula_t_cascata
  import modulo_contador_sync_param_pkg::*;
(
  input  logic clk,
  input  logic clr,
  input  logic t_in_up,
  input  logic t_in_dn,
  input  logic up_dn,
  input  logic en,
  input  logic reload,
  input  logic reload_val,
  output logic q,
  output logic t_out_up,
  output logic t_out_dn
);

  logic toggle;

  assign toggle = en & ((dir_e'(up_dn) == DIR_UP) ? t_in_up : t_in_dn);

  // Reload wins over toggling so a modulus wrap or parallel load lands cleanly on one edge
  always_ff @(posedge clk) begin
    if (clr)
      q <= 1'b0;
    else if (reload)
      q <= reload_val;
    else if (toggle)
      q <= ~q;
  end

  assign t_out_up = t_in_up & q;
  assign t_out_dn = t_in_dn & ~q;

endmodule

// File: rtl/modulo_contador_sync_param.sv
// Programmable-modulus synchronous up/down counter built from T cells.
// Define CONTADOR_SATURATE_EN to make the count stop at its limits instead of wrapping.
module modulo_contador_sync_param
  import modulo_contador_sync_param_pkg::*;
#(
  parameter int WIDTH   = 7,
  parameter int MODULUS = 100
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MAX_Q   = WIDTH'(MODULUS - 1);
  localparam logic             NATURAL = (longint'(MODULUS) == (longint'(1) << WIDTH));

  if (!modulus_ok(WIDTH, MODULUS)) begin : g_bad_modulus
    $error("modulo_contador_sync_param: MODULUS must lie in 2..2**WIDTH and WIDTH >= 2");
  end

  logic [WIDTH:0]   t_up;
  logic [WIDTH:0]   t_dn;
  logic             counting_up;
  logic             at_max;
  logic             at_zero;
  logic             at_limit;
  logic             load_in_range;
  logic [WIDTH-1:0] load_clamped;
  logic             cell_en;
  logic             reload;
  logic [WIDTH-1:0] reload_val;
  logic             wrap_next;

  assign t_up[0] = 1'b1;
  assign t_dn[0] = 1'b1;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    modulo_celula_t_cascata u_cell (
      .clk        (clk),
      .clr        (clr),
      .t_in_up    (t_up[i]),
      .t_in_dn    (t_dn[i]),
      .up_dn      (up_dn),
      .en         (cell_en),
      .reload     (reload),
      .reload_val (reload_val[i]),
      .q          (q[i]),
      .t_out_up   (t_up[i+1]),
      .t_out_dn   (t_dn[i+1])
    );
  end

  // The top of the AND chain is the carry/borrow out; with a power-of-two modulus it is the limit
  assign counting_up = (dir_e'(up_dn) == DIR_UP);
  assign at_max      = NATURAL ? t_up[WIDTH] : (q == MAX_Q);
  assign at_zero     = t_dn[WIDTH];
  assign at_limit    = counting_up ? at_max : at_zero;
  assign tc          = en & at_limit;

  assign load_in_range = ({1'b0, load_val} < (WIDTH+1)'(MODULUS));
  assign load_clamped  = load_in_range ? load_val : '0;

`ifdef CONTADOR_SATURATE_EN
  localparam logic [WIDTH-1:0] PRE_MAX = WIDTH'(MODULUS - 2);
  localparam logic [WIDTH-1:0] PRE_MIN = WIDTH'(1);

  // Freeze the cells at the limit; wrap flags the step that arrives there
  assign cell_en    = en & ~at_limit;
  assign reload     = load;
  assign reload_val = load_clamped;
  assign wrap_next  = en & (counting_up ? (q == PRE_MAX) : (q == PRE_MIN));
`else
  // A natural carry/borrow already rolls the bits over, so only short moduli need the reload
  assign cell_en    = en;
  assign reload     = load | (tc & ~NATURAL);
  assign reload_val = load ? load_clamped : (counting_up ? '0 : MAX_Q);
  assign wrap_next  = tc;
`endif

  always_ff @(posedge clk) begin
    if (clr)
      wrap <= 1'b0;
    else if (load)
      wrap <= 1'b0;
    else
      wrap <= wrap_next;
  end

endmodule

// File: tb/tb_modulo_contador_sync_param.sv
// Directed bench for modulo_contador_sync_param: main 7/100 instance, a two-stage cascade and a 4/16 instance.
module tb_modulo_contador_sync_param;

`ifdef CONTADOR_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       clr, en, up_dn, load;
  logic [6:0] load_val, q;
  logic       tc, wrap;

  logic       c_clr;
  logic [6:0] c0_q, c1_q;
  logic       c0_tc, c1_tc, c0_wrap, c1_wrap;

  logic       n_clr, n_en, n_up_dn, n_load;
  logic [3:0] n_load_val, n_q;
  logic       n_tc, n_wrap;

  int vectors = 0;
  int miscompares = 0;

  modulo_contador_sync_param #(.WIDTH(7), .MODULUS(100)) dut (
    .clk(clk), .clr(clr), .en(en), .up_dn(up_dn), .load(load),
    .load_val(load_val), .q(q), .tc(tc), .wrap(wrap)
  );

  modulo_contador_sync_param #(.WIDTH(7), .MODULUS(100)) u_c0 (
    .clk(clk), .clr(c_clr), .en(1'b1), .up_dn(1'b1), .load(1'b0),
    .load_val(7'd0), .q(c0_q), .tc(c0_tc), .wrap(c0_wrap)
  );

  modulo_contador_sync_param #(.WIDTH(7), .MODULUS(100)) u_c1 (
    .clk(clk), .clr(c_clr), .en(c0_tc), .up_dn(1'b1), .load(1'b0),
    .load_val(7'd0), .q(c1_q), .tc(c1_tc), .wrap(c1_wrap)
  );

  modulo_contador_sync_param #(.WIDTH(4), .MODULUS(16)) u_nat (
    .clk(clk), .clr(n_clr), .en(n_en), .up_dn(n_up_dn), .load(n_load),
    .load_val(n_load_val), .q(n_q), .tc(n_tc), .wrap(n_wrap)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic c, input logic e, input logic ud,
                               input logic l, input logic [6:0] lv);
    clr = c; en = e; up_dn = ud; load = l; load_val = lv;
  endtask

  task automatic checkOutput(input string tag, input int observed, input int expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  initial begin
    c_clr = 1'b1;
    n_clr = 1'b1; n_en = 1'b0; n_up_dn = 1'b1; n_load = 1'b0; n_load_val = 4'd0;

    // Reset beats load and enable
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 7'd55);
    tick();
    checkOutput("reset_q", int'(q), 0);
    checkOutput("reset_wrap", int'(wrap), 0);

    // Up across the top of the range
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 7'd98);
    tick();
    checkOutput("load98_q", int'(q), 98);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 7'd0);
    checkOutput("tc_at98", int'(tc), 0);
    tick();
    checkOutput("up_q99", int'(q), 99);
    checkOutput("up_tc99", int'(tc), 1);
    checkOutput("up_wrap_at99", int'(wrap), SAT ? 1 : 0);
    tick();
    checkOutput("up_wrap_q", int'(q), SAT ? 99 : 0);
    checkOutput("up_wrap_pulse", int'(wrap), SAT ? 0 : 1);
    tick();
    checkOutput("up_after_q", int'(q), SAT ? 99 : 1);
    checkOutput("up_after_wrap", int'(wrap), 0);

    // Down across zero; load ignores en
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 7'd0);
    tick();
    checkOutput("load0_q", int'(q), 0);
    checkOutput("load0_wrap", int'(wrap), 0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 7'd0);
    checkOutput("dn_tc0", int'(tc), 1);
    tick();
    checkOutput("dn_wrap_q", int'(q), SAT ? 0 : 99);
    checkOutput("dn_wrap_pulse", int'(wrap), SAT ? 0 : 1);
    tick();
    checkOutput("dn_after_q", int'(q), SAT ? 0 : 98);
    checkOutput("dn_after_wrap", int'(wrap), 0);

    // Direction flip at 50
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 7'd50);
    tick();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 7'd0);
    tick();
    checkOutput("flip_dn_q", int'(q), 49);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 7'd0);
    tick();
    checkOutput("flip_up_q", int'(q), 50);

    // Load priority and clamping
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 7'd42);
    tick();
    checkOutput("load42_q", int'(q), 42);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 7'd120);
    tick();
    checkOutput("load120_q", int'(q), 0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 7'd99);
    tick();
    checkOutput("load99_q", int'(q), 99);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 7'd0);
    checkOutput("tc_no_en", int'(tc), 0);
    tick();
    checkOutput("hold_q", int'(q), 99);
    checkOutput("hold_wrap", int'(wrap), 0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 7'd100);
    tick();
    checkOutput("load100_q", int'(q), 0);

    // Reset mid-count
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 7'd0);
    tick(); tick(); tick();
    checkOutput("count3_q", int'(q), 3);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 7'd0);
    tick();
    checkOutput("midclr_q", int'(q), 0);
    checkOutput("midclr_wrap", int'(wrap), 0);

    // Cascade: lower tc enables the upper stage
    c_clr = 1'b0;
    repeat (1000) tick();
    checkOutput("chain_lower_q", int'(c0_q), SAT ? 99 : 0);
    checkOutput("chain_upper_q", int'(c1_q), SAT ? 99 : 10);

    // Power-of-two modulus relies on the natural carry/borrow
    n_clr = 1'b0; n_load = 1'b1; n_load_val = 4'd14;
    tick();
    checkOutput("nat_load14_q", int'(n_q), 14);
    n_load = 1'b0; n_en = 1'b1; n_up_dn = 1'b1;
    tick();
    checkOutput("nat_q15", int'(n_q), 15);
    checkOutput("nat_tc15", int'(n_tc), 1);
    tick();
    checkOutput("nat_up_wrap_q", int'(n_q), SAT ? 15 : 0);
    checkOutput("nat_up_wrap_pulse", int'(n_wrap), SAT ? 0 : 1);
    n_load = 1'b1; n_load_val = 4'd0;
    tick();
    n_load = 1'b0; n_up_dn = 1'b0;
    tick();
    checkOutput("nat_dn_wrap_q", int'(n_q), SAT ? 0 : 15);
    checkOutput("nat_dn_wrap_pulse", int'(n_wrap), SAT ? 0 : 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
